shift_sweep: RTL and testbench

SHIFT_SWEEP -- requirements
Module: shift_sweep

---
 rtl/shift_sweep.sv | 191 +++++++++++++++++++
 tb/tb_shift_sweep.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sweep.sv
// shift_sweep: walks an operand through every select code enabled in a mask,
// driving an external combinational shifter and handing each captured result
// to a consumer with a valid/ready handshake. Codes are visited in ascending
// order; each code is held for HOLD_CYCLES cycles before the result is sampled.
module shift_sweep #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [7:0] in_mask,
    input  logic       abort,
    output logic [2:0] sh_s,
    output logic [3:0] sh_d,
    input  logic [3:0] sh_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [2:0] out_sel,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Hold counter counts down to zero; zero marks the sampling cycle.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 32'd1);
    // Returned by first_set_from when no enabled code remains.
    localparam logic [3:0] SEL_NONE  = 4'd8;

    // Lowest set mask bit at index >= start, or SEL_NONE.
    function automatic logic [3:0] first_set_from(input logic [7:0] mask,
                                                  input logic [3:0] start);
        logic [3:0] found;
        found = SEL_NONE;
        for (int k = 7; k >= 0; k--) begin
            if ((4'(k) >= start) && mask[k]) begin
                found = 4'(k);
            end else begin
                found = found;
            end
        end
        return found;
    endfunction

    state_t     state_r, state_next_s;
    logic [7:0] mask_r, mask_next_s;
    logic [2:0] sh_s_r, sh_s_next_s;
    logic [3:0] sh_d_r, sh_d_next_s;
    logic [3:0] hold_r, hold_next_s;
    logic [3:0] out_data_r, out_data_next_s;
    logic [2:0] out_sel_r, out_sel_next_s;
    logic       out_valid_r, out_valid_next_s;
    logic       out_last_r, out_last_next_s;
    logic       done_r, done_next_s;
    logic       busy_r, busy_next_s;
    logic       in_ready_r, in_ready_next_s;

    logic [3:0] lowest_s;
    logic [3:0] after_emit_s;
    logic [3:0] after_drive_s;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mask_r      <= 8'h00;
            sh_s_r      <= 3'd0;
            sh_d_r      <= 4'd0;
            hold_r      <= 4'd0;
            out_data_r  <= 4'd0;
            out_sel_r   <= 3'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            mask_r      <= mask_next_s;
            sh_s_r      <= sh_s_next_s;
            sh_d_r      <= sh_d_next_s;
            hold_r      <= hold_next_s;
            out_data_r  <= out_data_next_s;
            out_sel_r   <= out_sel_next_s;
            out_valid_r <= out_valid_next_s;
            out_last_r  <= out_last_next_s;
            done_r      <= done_next_s;
            busy_r      <= busy_next_s;
            in_ready_r  <= in_ready_next_s;
        end
    end

    // Next-state and next-output decode; abort always beats the result handshake.
    always_comb begin
        state_next_s     = state_r;
        mask_next_s      = mask_r;
        sh_s_next_s      = sh_s_r;
        sh_d_next_s      = sh_d_r;
        hold_next_s      = hold_r;
        out_data_next_s  = out_data_r;
        out_sel_next_s   = out_sel_r;
        out_valid_next_s = out_valid_r;
        out_last_next_s  = out_last_r;
        done_next_s      = 1'b0;

        lowest_s      = first_set_from(in_mask, 4'd0);
        after_emit_s  = first_set_from(mask_r, {1'b0, out_sel_r} + 4'd1);
        after_drive_s = first_set_from(mask_r, {1'b0, sh_s_r} + 4'd1);

        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    mask_next_s = in_mask;
                    if (in_mask != 8'h00) begin
                        state_next_s = ST_DRIVE;
                        sh_s_next_s  = lowest_s[2:0];
                        sh_d_next_s  = in_data;
                        hold_next_s  = HOLD_LOAD;
                    end else begin
                        // Empty sweep: nothing to emit, just report completion.
                        done_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                    hold_next_s  = 4'd0;
                end else if (hold_r == 4'd0) begin
                    state_next_s     = ST_EMIT;
                    out_data_next_s  = sh_y;
                    out_sel_next_s   = sh_s_r;
                    out_valid_next_s = 1'b1;
                    out_last_next_s  = (after_drive_s == SEL_NONE);
                end else begin
                    hold_next_s = hold_r - 4'd1;
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    state_next_s     = ST_IDLE;
                    out_valid_next_s = 1'b0;
                    out_last_next_s  = 1'b0;
                end else if (out_ready) begin
                    out_valid_next_s = 1'b0;
                    if (out_last_r) begin
                        state_next_s    = ST_IDLE;
                        out_last_next_s = 1'b0;
                        done_next_s     = 1'b1;
                    end else begin
                        state_next_s = ST_DRIVE;
                        sh_s_next_s  = after_emit_s[2:0];
                        hold_next_s  = HOLD_LOAD;
                    end
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                out_valid_next_s = 1'b0;
                out_last_next_s  = 1'b0;
                hold_next_s      = 4'd0;
            end
        endcase

        busy_next_s     = (state_next_s != ST_IDLE);
        in_ready_next_s = (state_next_s == ST_IDLE);
    end

    assign in_ready  = in_ready_r;
    assign sh_s      = sh_s_r;
    assign sh_d      = sh_d_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_shift_sweep.sv
// Testbench for shift_sweep: scoreboard of expected results fed from a
// mask-walking reference model, a negedge monitor that compares, plus a
// second instance with HOLD_CYCLES=4 for hold/latency checks.
module tb_shift_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, abort, out_valid, out_ready, out_last, busy, done;
    logic [3:0] in_data, sh_d, sh_y, out_data;
    logic [7:0] in_mask, dd;
    logic [2:0] sh_s, out_sel;

    logic       in_valid4, in_ready4, abort4, out_valid4, out_ready4, out_last4, busy4, done4;
    logic [3:0] in_data4, sh_d4, sh_y4, out_data4;
    logic [7:0] in_mask4, dd4;
    logic [2:0] sh_s4, out_sel4;

    // Shifter stub: rotate left by sh_s[1:0].
    assign dd    = {sh_d, sh_d} << sh_s[1:0];
    assign sh_y  = dd[7:4];
    assign dd4   = {sh_d4, sh_d4} << sh_s4[1:0];
    assign sh_y4 = dd4[7:4];

    shift_sweep #(.HOLD_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .abort(abort), .sh_s(sh_s),
        .sh_d(sh_d), .sh_y(sh_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
        .busy(busy), .done(done)
    );

    shift_sweep #(.HOLD_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_mask(in_mask4), .abort(abort4), .sh_s(sh_s4),
        .sh_d(sh_d4), .sh_y(sh_y4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_sel(out_sel4), .out_last(out_last4),
        .busy(busy4), .done(done4)
    );

    typedef struct {
        int data;
        int sel;
        int last;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         pend_done = 0;
    int         rdy_ctl = 1;
    logic [7:0] cur_mask = 8'h00;
    logic [3:0] cur_data = 4'd0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rotl(input int d, input int r);
        return ((d << r) | (d >> (4 - r))) & 15;
    endfunction

    // Reference model: one result per set mask bit, ascending, last on the highest.
    task automatic push_model(input int d, input int m);
        int hi;
        hi = -1;
        for (int k = 0; k < 8; k++) if (((m >> k) & 1) == 1) hi = k;
        for (int k = 0; k < 8; k++) begin
            if (((m >> k) & 1) == 1) q.push_back('{rotl(d, k % 4), k, int'(k == hi)});
        end
    endtask

    // out_ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_ctl)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares outputs to the scoreboard head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_done = 0;
            end else begin
                chk("done_pulse", int'(done), pend_done);
                pend_done = 0;
                if (in_valid && in_ready && in_mask == 8'h00) pend_done = 1;
                if (busy && !out_valid) begin
                    chk("drive_sel_enabled", int'(cur_mask[sh_s]), 1);
                    chk("drive_data", int'(sh_d), int'(cur_data));
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        chk("out_data", int'(out_data), q[0].data);
                        chk("out_sel", int'(out_sel), q[0].sel);
                        chk("out_last", int'(out_last), q[0].last);
                        if (out_ready && !abort) begin
                            if (q[0].last == 1) pend_done = 1;
                            void'(q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [7:0] m);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        chk("send_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        tick(1);
        in_valid = 1'b0;
        cur_mask = m;
        cur_data = d;
        push_model(int'(d), int'(m));
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while ((busy || q.size() != 0) && guard < 500) begin
            tick(1);
            guard++;
        end
        chk(name, int'(busy) + q.size(), 0);
        tick(2);
    endtask

    initial begin
        int cnt;
        int first_v;
        int guard;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 4'd0; in_mask = 8'h00; abort = 1'b0;
        in_valid4 = 1'b0; in_data4 = 4'd0; in_mask4 = 8'h00; abort4 = 1'b0;
        out_ready4 = 1'b1;
        #12;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sh_s", int'(sh_s), 0);
        chk("rst_sh_d", int'(sh_d), 0);
        chk("rst_in_ready4", int'(in_ready4), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        chk("in_ready_after_release", int'(in_ready), 1);

        // Full mask, consumer always ready: 8 results, one every 2 cycles.
        send(4'b0001, 8'hFF);
        cnt = 0;
        first_v = -1;
        while (!done && cnt < 100) begin
            tick(1);
            cnt++;
            if (out_valid && first_v < 0) first_v = cnt;
        end
        chk("first_result_latency", first_v, 1);
        chk("ff_sweep_cycles_to_done", cnt, 16);
        wait_idle("ff_sweep_drained");

        // Sparse mask with a stalled consumer; monitor checks stability each cycle.
        rdy_ctl = 0;
        tick(1);
        send(4'b1010, 8'b1000_0100);
        tick(6);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_out_sel", int'(out_sel), 2);
        rdy_ctl = 1;
        wait_idle("sparse_sweep_drained");

        // Empty mask: only a done pulse, still ready.
        send(4'b0110, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("empty_no_valid", int'(out_valid), 0);
            chk("empty_in_ready", int'(in_ready), 1);
            tick(1);
        end

        // Abort on the second emitted result, colliding with its handshake.
        send(4'b0011, 8'hFF);
        guard = 0;
        while (!(out_valid && out_sel == 3'd1) && guard < 100) begin
            tick(1);
            guard++;
        end
        chk("abort_reach_second_emit", int'(out_valid && out_sel == 3'd1), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        q.delete();
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        tick(2);
        rdy_ctl = 2;
        send(4'b0111, 8'h22);
        wait_idle("post_abort_sweep");

        // Random operands, masks, back-pressure and occasional aborts.
        for (int it = 0; it < 25; it++) begin
            send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(0, 10));
                if (busy) begin
                    abort = 1'b1;
                    tick(1);
                    abort = 1'b0;
                    q.delete();
                    chk("rand_abort_idle", int'(busy), 0);
                end
            end
            wait_idle("rand_sweep_drained");
        end

        // Asynchronous reset in the middle of DRIVE.
        rdy_ctl = 1;
        tick(1);
        send(4'b0101, 8'hF0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sh_s", int'(sh_s), 0);
        chk("midrst_sh_d", int'(sh_d), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_sel", int'(out_sel), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        chk("midrst_release_ready", int'(in_ready), 1);
        chk("midrst_release_busy", int'(busy), 0);
        send(4'b1001, 8'h81);
        wait_idle("post_reset_sweep");

        // HOLD_CYCLES=4: code 0 held 4 cycles, result in cycle 5 after handshake.
        in_valid4 = 1'b1;
        in_data4  = 4'b0110;
        in_mask4  = 8'h01;
        chk("h4_ready", int'(in_ready4), 1);
        tick(1);
        in_valid4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("h4_hold_sel", int'(sh_s4), 0);
            chk("h4_hold_no_valid", int'(out_valid4), 0);
            chk("h4_hold_busy", int'(busy4), 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("h4_out_valid", int'(out_valid4), 1);
        chk("h4_out_data", int'(out_data4), 6);
        chk("h4_out_sel", int'(out_sel4), 0);
        chk("h4_out_last", int'(out_last4), 1);
        @(posedge clk);
        #1;
        chk("h4_done", int'(done4), 1);
        chk("h4_in_ready", int'(in_ready4), 1);
        tick(1);
        chk("h4_done_single", int'(done4), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
